// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one operation at a time to an external combinational
// ALU. Single-cycle ops complete straight from EXEC. Mul and div first wait a
// fixed number of cycles. The result is held until the consumer takes it.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,  // execute cycles for mul (1..15)
  parameter int unsigned DIV_CYCLES = 8   // execute cycles for div (1..15)
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_c0,
  input  logic [31:0] alu_c1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // The counter starts at N-1 and the response is latched on the cycle it reads 0.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  // The ALU sees the captured operands. They stay constant until the next accept.
  assign alu_a       = a;
  assign alu_b       = b;
  assign alu_control = op;

  // Handshake flags are plain decodes of the state register.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_zero  = (rsp_lo == 32'd0);

  // Sequencer FSM: capture the request, execute or wait, then hold the response.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op      <= 4'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      rsp_lo  <= 32'd0;
      rsp_hi  <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op    <= req_op;
            a     <= req_a;
            b     <= req_b;
            state <= EXEC;
          end
        end

        EXEC: begin
          case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12: begin
              rsp_lo  <= alu_c0;
              rsp_hi  <= 32'd0;
              rsp_err <= 1'b0;
              state   <= DONE;
            end
            OP_MUL: begin
              cnt   <= MUL_LOAD;
              state <= WAIT;
            end
            OP_DIV: begin
              if (b == 32'd0) begin
                rsp_lo  <= 32'd0;
                rsp_hi  <= 32'd0;
                rsp_err <= 1'b1;
                state   <= DONE;
              end else begin
                cnt   <= DIV_LOAD;
                state <= WAIT;
              end
            end
            default: begin
              // Codes 13-15 are not ALU operations.
              rsp_lo  <= 32'd0;
              rsp_hi  <= 32'd0;
              rsp_err <= 1'b1;
              state   <= DONE;
            end
          endcase
        end

        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_lo  <= alu_c0;
            rsp_hi  <= alu_c1;
            rsp_err <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A small ALU stub drives alu_c0/c1
// from the DUT's ALU outputs. A transaction-level model predicts every
// visible output on each cycle. Directed vectors carry hand-computed results
// and latencies.
module tb_alu_sequencer;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [31:0] alu_c0;
  logic [31:0] alu_c1;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_zero;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic [3:0]  alu_control;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .nRst(nRst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_c0(alu_c0), .alu_c1(alu_c1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {c1, c0}. Single-result ops put junk in c1
  // so that a sequencer forwarding c1 for them gets caught.
  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] t;
    logic [4:0]  sh;
    logic [31:0] junk;
    sh   = y[4:0];
    junk = x ^ y ^ 32'h5A5A_0000;
    case (op)
      4'd0:  return {junk, x + y};
      4'd1:  return {junk, x - y};
      4'd2:  return {junk, x & y};
      4'd3:  return {junk, x | y};
      4'd4:  begin t = {x, x} >> sh; return {junk, t[31:0]}; end
      4'd5:  begin t = {x, x} << sh; return {junk, t[63:32]}; end
      4'd6:  return {junk, x >> sh};
      4'd7:  return {junk, 32'($signed(x) >>> sh)};
      4'd8:  return {junk, x << sh};
      4'd9:  return (y != 32'd0) ? {x % y, x / y} : {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      4'd10: return 64'(x) * 64'(y);
      4'd11: return {junk, 32'd0 - x};
      4'd12: return {junk, ~x};
      default: return {junk, 32'hDEAD_BEEF};
    endcase
  endfunction

  always_comb begin
    {alu_c1, alu_c0} = alu_ref(alu_control, alu_a, alu_b);
  end

  // Expected response {err, hi, lo} for a request.
  function automatic logic [64:0] exp_response(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
    logic [63:0] r;
    r = alu_ref(op, x, y);
    if (op > 4'd12 || (op == 4'd9 && y == 32'd0)) return {1'b1, 64'd0};
    if (op == 4'd9 || op == 4'd10) return {1'b0, r};
    return {1'b0, 32'd0, r[31:0]};
  endfunction

  // Edges after the accept edge until the response is visible.
  function automatic int exp_latency(input logic [3:0] op, input logic [31:0] y);
    if (op == 4'd10) return MUL_CYCLES + 1;
    if (op == 4'd9 && y != 32'd0) return DIV_CYCLES + 1;
    return 1;
  endfunction

  // Transaction model: busy between accept and handshake, response after a countdown.
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_lat = 0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_hi = 32'd0;
  logic        m_err = 1'b0;
  logic [64:0] m_pend = 65'd0;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_lat <= 0;
      m_op <= 4'd0; m_a <= 32'd0; m_b <= 32'd0;
      m_lo <= 32'd0; m_hi <= 32'd0; m_err <= 1'b0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        m_valid <= 1'b1;
        {m_err, m_hi, m_lo} <= m_pend;
      end
    end else if (req_valid) begin
      m_busy <= 1'b1;
      m_op   <= req_op;
      m_a    <= req_a;
      m_b    <= req_b;
      m_lat  <= exp_latency(req_op, req_b);
      m_pend <= exp_response(req_op, req_a, req_b);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_req_ready",   req_ready,   !m_busy);
    check("cyc_rsp_valid",   rsp_valid,   m_valid);
    check("cyc_rsp_lo",      rsp_lo,      m_lo);
    check("cyc_rsp_hi",      rsp_hi,      m_hi);
    check("cyc_rsp_err",     rsp_err,     m_err);
    check("cyc_rsp_zero",    rsp_zero,    m_lo == 32'd0);
    check("cyc_alu_a",       alu_a,       m_a);
    check("cyc_alu_b",       alu_b,       m_b);
    check("cyc_alu_control", alu_control, m_op);
  end

  // One request with hand-computed result. The latency counts edges, and the accept edge is edge 1.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] lo, input logic [31:0] hi,
                        input logic err, input int edges);
    int n;
    bit ready_seen;
    @(negedge clk);
    check({name, "_ready_before"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = x; req_b = y;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd15; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
    n = 1;
    ready_seen = 1'b0;
    while (!rsp_valid && n < 64) begin
      ready_seen |= req_ready;
      @(posedge clk); #1;
      n++;
    end
    ready_seen |= req_ready;
    check({name, "_latency"}, n, edges);
    check({name, "_lo"}, rsp_lo, lo);
    check({name, "_hi"}, rsp_hi, hi);
    check({name, "_err"}, rsp_err, err);
    check({name, "_zero"}, rsp_zero, lo == 32'd0);
    check({name, "_ready_low"}, ready_seen, 1'b0);
    n = 0;
    while (!req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_back_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    int  n;
    bit  seen;

    // Reset with a request already asserted: nothing may be consumed.
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'h1234_5678; req_b = 32'h9;
    repeat (3) @(negedge clk);
    check("rst_req_ready",   req_ready,   1'b1);
    check("rst_rsp_valid",   rsp_valid,   1'b0);
    check("rst_rsp_zero",    rsp_zero,    1'b1);
    check("rst_rsp_err",     rsp_err,     1'b0);
    check("rst_rsp_lo",      rsp_lo,      32'd0);
    check("rst_alu_control", alu_control, 4'd0);
    check("rst_alu_a",       alu_a,       32'd0);
    req_valid = 1'b0;
    nRst = 1'b1;
    rsp_ready = 1'b1;

    run_op("add",    4'd0,  32'd5,         32'd7,  32'd12,        32'd0, 1'b0, 2);
    run_op("mul",    4'd10, 32'd3,         32'd4,  32'd12,        32'd0, 1'b0, MUL_CYCLES + 2);
    run_op("div0",   4'd9,  32'd9,         32'd0,  32'd0,         32'd0, 1'b1, 2);
    run_op("ill14",  4'd14, 32'd9,         32'd3,  32'd0,         32'd0, 1'b1, 2);
    run_op("div",    4'd9,  32'd100,       32'd7,  32'd14,        32'd2, 1'b0, DIV_CYCLES + 2);
    run_op("mulbig", 4'd10, 32'hFFFF_FFFF, 32'd2,  32'hFFFF_FFFE, 32'd1, 1'b0, MUL_CYCLES + 2);
    run_op("rotr",   4'd4,  32'h0000_0013, 32'd4,  32'h3000_0001, 32'd0, 1'b0, 2);
    run_op("shra",   4'd7,  32'h8000_0000, 32'd4,  32'hF800_0000, 32'd0, 1'b0, 2);
    run_op("neg",    4'd11, 32'd5,         32'd0,  32'hFFFF_FFFB, 32'd0, 1'b0, 2);
    run_op("and",    4'd2,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 32'd0, 1'b0, 2);

    // Backpressure: sub 1-1 held for 5 cycles while another request waits.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd1; req_b = 32'd1;
    @(posedge clk); #1;
    req_op = 4'd0; req_a = 32'd2; req_b = 32'd3;
    @(posedge clk); #1;
    check("bp_valid_at_2", rsp_valid, 1'b1);
    repeat (5) begin
      check("bp_valid_held", rsp_valid,   1'b1);
      check("bp_ready_low",  req_ready,   1'b0);
      check("bp_lo",         rsp_lo,      32'd0);
      check("bp_zero",       rsp_zero,    1'b1);
      check("bp_ctrl_held",  alu_control, 4'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_hs", req_ready,   1'b1);
    check("bp_valid_dropped", rsp_valid,   1'b0);
    check("bp_no_load_at_hs", alu_control, 4'd1);
    @(posedge clk); #1;
    check("bp_next_ctrl", alu_control, 4'd0);
    check("bp_next_a",    alu_a,       32'd2);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_next_lo", rsp_lo, 32'd5);
    n = 0;
    while (!req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end

    // Reset during the third WAIT cycle of div 100/5.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd9; req_a = 32'd100; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 nRst = 1'b0;
    #1;
    check("mrst_req_ready", req_ready,   1'b1);
    check("mrst_rsp_valid", rsp_valid,   1'b0);
    check("mrst_alu_ctrl",  alu_control, 4'd0);
    check("mrst_alu_a",     alu_a,       32'd0);
    check("mrst_alu_b",     alu_b,       32'd0);
    check("mrst_rsp_lo",    rsp_lo,      32'd0);
    check("mrst_rsp_hi",    rsp_hi,      32'd0);
    check("mrst_rsp_zero",  rsp_zero,    1'b1);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    check("mrst_no_rsp", seen, 1'b0);
    run_op("after_rst", 4'd0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
